// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives an 8N1 program image, writes it to memory from address 0,
// and releases the CPU once the XOR checksum of the payload matches.
module uart_boot_loader #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  mem_chip_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int GW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW   = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} ld_state_t;
  rx_state_t rs_q, rs_d;
  ld_state_t ls_q, ls_d;
  logic rx_s1_q, rx_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic byte_valid, frame_err;
  logic [IW-1:0] n_q, n_d, idx_q, idx_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0] csum_q, csum_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0] err_code_q, err_code_d;
  logic mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  always_comb begin
    rs_d = rs_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        rs_d = rx_s2_q ? R_IDLE : R_START;
      end
      R_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        rs_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        sh_d = {rx_s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        rs_d = (bit_q == 3'd7) ? R_STOP : R_DATA;
      end
      default: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        byte_valid = rx_s2_q;
        frame_err = !rx_s2_q;
        rs_d = R_IDLE;
      end
    endcase
  end
  always_comb begin
    ls_d = ls_q;
    n_d = n_q;
    idx_d = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    csum_d = csum_q;
    gap_d = '0;
    err_code_d = err_code_q;
    mem_wr_en_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    case (ls_q)
      IDLE: if (byte_valid) begin
        n_d = IW'(sh_q);
        idx_d = '0;
        bcnt_d = '0;
        csum_d = '0;
        if (32'(sh_q) > (32'd1 << ADDR_WIDTH)) begin
          ls_d = ERROR;
          err_code_d = 2'b10;
        end else
          ls_d = (sh_q == 8'd0) ? CHECK : LOAD;
      end
      LOAD: begin
        gap_d = byte_valid ? '0 : gap_q + 1'b1;
        if (byte_valid) begin
          word_d = {sh_q, word_q[DATA_WIDTH-1:8]};
          csum_d = csum_q ^ sh_q;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            mem_wr_en_d = 1'b1;
            mem_addr_d = idx_q[ADDR_WIDTH-1:0];
            mem_wr_data_d = {sh_q, word_q[DATA_WIDTH-1:8]};
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q == n_q)
          ls_d = CHECK;
      end
      CHECK: begin
        gap_d = gap_q + 1'b1;
        if (byte_valid) begin
          ls_d = (sh_q == csum_q) ? DONE : ERROR;
          err_code_d = (sh_q == csum_q) ? err_code_q : 2'b10;
        end
      end
      default: ;
    endcase
    if (frame_err && ls_q != DONE && ls_q != ERROR) begin
      ls_d = ERROR;
      err_code_d = 2'b01;
    end
    if ((ls_q == LOAD || ls_q == CHECK) && !byte_valid && gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
      ls_d = ERROR;
      err_code_d = 2'b11;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rs_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      ls_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      csum_q <= '0;
      gap_q <= '0;
      err_code_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rs_q <= rs_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      ls_q <= ls_d;
      n_q <= n_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      csum_q <= csum_d;
      gap_q <= gap_d;
      err_code_q <= err_code_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_chip_sel = mem_wr_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign cpu_hold     = ls_q != DONE;
  assign done         = ls_q == DONE;
  assign error        = ls_q == ERROR;
  assign err_code     = err_code_q;
endmodule
